ws2812_tx: RTL

Serial LED-strip transmitter that drains pixel words from a `simple_fifo` read port and serializes them onto a single-wire WS2812-style line. It uses a valid/ready consumer handshake, with one word per LED and MSB first. Bit period, high times and latch gap are set by parameters in clock cycles. A gap in the incoming stream ends the frame: the block drives the latch/reset low time and then pulses `frame_done`.

---
 rtl/ws2812_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ws2812_tx.sv
// WS2812-style single-wire LED transmitter: pulls pixel words over valid/ready,
// shifts them out MSB first as timed high/low pulses, then drives the latch gap.
module ws2812_tx #(
  parameter int DSIZE   = 24,
  parameter int CNT_W   = 16,
  parameter int T0H     = 20,
  parameter int T1H     = 40,
  parameter int T_BIT   = 63,
  parameter int T_RESET = 2500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_n,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             led_out,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam int BCW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

  // Terminal counts: the timing counter runs 0..N-1 within each phase.
  localparam logic [CNT_W-1:0] T0H_LAST  = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T1H_LAST  = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T0L_LAST  = CNT_W'(T_BIT - T0H - 1);
  localparam logic [CNT_W-1:0] T1L_LAST  = CNT_W'(T_BIT - T1H - 1);
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(T_RESET - 1);
  localparam logic [BCW-1:0]   BIT_TOP   = BCW'(DSIZE - 1);

  logic [1:0]       state_reg, state_next;
  logic [DSIZE-1:0] shift_reg, shift_next;
  logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic             led_reg, led_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             run;
  logic             cur_bit;
  logic [CNT_W-1:0] high_last;
  logic [CNT_W-1:0] low_last;
  logic             low_end;
  logic             accept;

  assign run       = !rst && clear_n;
  assign cur_bit   = shift_reg[DSIZE-1];
  assign high_last = cur_bit ? T1H_LAST : T0H_LAST;
  assign low_last  = cur_bit ? T1L_LAST : T0L_LAST;
  assign low_end   = (state_reg == S_LOW) && (tcnt_reg == low_last);

  // Ready in the last LOW cycle of the last bit so back-to-back words abut.
  assign in_ready = run && ((state_reg == S_IDLE) ||
                            (low_end && (bit_cnt_reg == '0)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    tcnt_next    = tcnt_reg + CNT_W'(1);
    done_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        tcnt_next = '0;
        if (accept) begin
          shift_next   = in_data;
          bit_cnt_next = BIT_TOP;
          state_next   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tcnt_reg == high_last) begin
          state_next = S_LOW;
          tcnt_next  = '0;
        end
      end
      S_LOW: begin
        if (low_end) begin
          tcnt_next = '0;
          if (bit_cnt_reg != '0) begin
            shift_next   = shift_reg << 1;
            bit_cnt_next = bit_cnt_reg - BCW'(1);
            state_next   = S_HIGH;
          end else if (accept) begin
            shift_next   = in_data;
            bit_cnt_next = BIT_TOP;
            state_next   = S_HIGH;
          end else begin
            state_next = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (tcnt_reg == TRST_LAST) begin
          state_next = S_IDLE;
          tcnt_next  = '0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        tcnt_next  = '0;
      end
    endcase

    led_next  = (state_next == S_HIGH);
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tcnt_reg    <= '0;
      led_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tcnt_reg    <= tcnt_next;
      led_reg     <= led_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign led_out    = led_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule
